reg_status_file: RTL and testbench
==================================

Name: reg_status_file

Overview:
- Tomasulo register file plus register-status table: each architectural register holds a value, a busy bit and a producer tag.
- Dispatch renames a destination register to a reservation-station/ROB tag.
- The common data bus (CDB) writes results back by tag match; reads return either a ready value or a tag to wait on.
- Read side sits between the instruction parser and the reservation stations; the write side hangs on the CDB. Supersedes the plain 32x64 regfile: parametrised ports, tag tracking, same-cycle CDB bypass, flush.

Parameters:
- NUM_REGS, 32, architectural register count; index NUM_REGS-1 is XZR (hardwired zero).
- DATA_W, 64, register value width.
- TAG_W, 4, producer tag width.
- NUM_RD, 2, number of read ports.
- IDX_W (localparam), $clog2(NUM_REGS), register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rd_idx  in  NUM_RD*IDX_W  packed read indices; port p at [p*IDX_W +: IDX_W].
- rd_value  out  NUM_RD*DATA_W  read values.
- rd_busy  out  NUM_RD  1 = value not yet produced; consumer must wait on rd_tag.
- rd_tag  out  NUM_RD*TAG_W  producer tag, valid when rd_busy=1.
- ren_valid  in  1  rename request.
- ren_idx  in  IDX_W  destination register to rename.
- ren_tag  in  TAG_W  new producer tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcasting tag.
- cdb_value  in  DATA_W  broadcast result.
- flush  in  1  mispredict recovery: clear all busy bits.
- busy_count  out  IDX_W+1  number of busy registers, registered.

Behaviour:
Reset (async, rst=1):
- All values 0, busy 0, tags 0, busy_count 0.
- Takes effect immediately and mid-operation; pending renames are lost.

Read ports (combinational, NUM_RD independent):
- rd_idx = XZR: value 0, busy 0, tag 0.
- Register not busy: stored value, busy 0.
- Register busy, and cdb_valid=1 with cdb_tag equal to its tag: bypass. Return cdb_value, busy 0.
- Register busy otherwise: return stored value (don't-care), busy 1, stored tag.
- A read in the same cycle as a rename of that register returns the pre-rename state.

CDB writeback (posedge clk):
- For every register with busy=1 and tag==cdb_tag: value<=cdb_value, busy<=0.
- Multiple matching registers are all updated; no match means no effect.

Rename (posedge clk):
- ren_valid=1 and ren_idx != XZR: busy<=1, tag<=ren_tag.
- Rename to XZR is ignored.
- Rename over an already-busy register overwrites the tag (WAW). The older producer's later broadcast then does not match.

Rename and CDB hit the same register in one cycle:
- Rename wins on busy and tag: busy stays 1, tag = ren_tag.
- Value is still written with cdb_value.

Flush (posedge clk):
- All busy<=0; values unchanged.
- Rename and CDB in the same cycle are ignored. Flush has highest priority below rst.

busy_count:
- Registered popcount of the next-state busy vector; updates one cycle after the causing edge.
- Range 0..NUM_REGS-1, since XZR is never busy.
- ren_idx >= NUM_REGS: ignored.

Decomposition:
- Shared package (tomasulo_pkg): XZR index constant, default DATA_W/TAG_W, and a struct for the CDB bundle (valid, tag, value) reused by reservation stations.
- Sub-module reg_status_entry: one register holding value/busy/tag and implementing the rename/CDB/flush priority.
- Top level instantiates NUM_REGS-1 entries (XZR constant), plus the read muxes with bypass and the popcount.

Test Plan:
- Reset: assert rst mid-run after renaming r3 to tag 5 -> r3 reads value 0, busy 0; busy_count=0 one cycle after release.
- Rename then broadcast: rename r3 to tag 5; next cycle read r3 -> busy 1, tag 5. Broadcast cdb_tag=5, value 0xDEAD -> same-cycle read bypasses 0xDEAD, busy 0; after the edge, stored value is 0xDEAD and busy 0.
- WAW: rename r4 to tag 1, then r4 to tag 2. Broadcast tag 1 -> r4 stays busy with tag 2. Broadcast tag 2, value 7 -> r4=7, busy 0.
- Simultaneous rename and CDB on r6 (old tag 3, new tag 9, cdb_tag 3, value 0x11) -> r6 busy 1, tag 9, stored value 0x11.
- Flush: three registers busy, flush with rename r1 and cdb_valid asserted -> all busy 0, r1 not renamed, values unchanged, busy_count=0 next cycle.
- XZR: rename r31 to tag 2 and read r31 on both ports -> busy 0, value 0; busy_count unchanged. Two read ports on different busy registers sharing tag 4 during broadcast of tag 4 -> both bypass.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, the hardwired-zero register
// index and the CDB broadcast bundle used by the register file and the
// reservation stations.
package tomasulo_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_DATA_W   = 64;
  localparam int DEFAULT_TAG_W    = 4;
  localparam int DEFAULT_NUM_RD   = 2;

  // Highest architectural index reads as zero and is never renamed.
  localparam int XZR_IDX = DEFAULT_NUM_REGS - 1;

  // One common-data-bus broadcast.
  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_TAG_W-1:0]  tag;
    logic [DEFAULT_DATA_W-1:0] value;
  } cdb_t;

endpackage : tomasulo_pkg

// File: rtl/reg_status_entry.sv
// One architectural register: value, busy bit and producer tag, with the
// flush > rename > CDB priority for busy/tag and CDB-only value update.
module reg_status_entry
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TAG_W  = DEFAULT_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_hit,
  input  logic [TAG_W-1:0]  ren_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              flush,
  output logic [DATA_W-1:0] value_q,
  output logic              busy_q,
  output logic [TAG_W-1:0]  tag_q,
  output logic              busy_next
);

  logic [DATA_W-1:0] value_d;
  logic              busy_d;
  logic [TAG_W-1:0]  tag_d;
  logic              cdb_hit;

  assign cdb_hit = cdb_valid && busy_q && (tag_q == cdb_tag);

  // Next-state selection: flush clears busy only; otherwise the CDB
  // retires the producer and a same-cycle rename re-arms busy/tag.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else begin
      if (cdb_hit) begin
        value_d = cdb_value;
        busy_d  = 1'b0;
      end
      if (ren_hit) begin
        busy_d = 1'b1;
        tag_d  = ren_tag;
      end
    end
  end

  assign busy_next = busy_d;

  // State register with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering. The value is
  // reset as well, because reads of a freshly reset register must return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      busy_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

endmodule : reg_status_entry

// File: rtl/reg_status_file.sv
// Tomasulo register file with register-status table: rename on dispatch,
// tag-matched CDB writeback, combinational reads with same-cycle CDB bypass,
// flush of all busy bits, and a registered busy-register count.
module reg_status_file
  import tomasulo_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int TAG_W    = DEFAULT_TAG_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_value,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic                     ren_valid,
  input  logic [IDX_W-1:0]         ren_idx,
  input  logic [TAG_W-1:0]         ren_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_value,
  input  logic                     flush,
  output logic [IDX_W:0]           busy_count
);

  localparam int NUM_ENT = NUM_REGS - 1;  // XZR has no storage

  logic [DATA_W-1:0]  ent_value [NUM_ENT];
  logic [TAG_W-1:0]   ent_tag   [NUM_ENT];
  logic [NUM_ENT-1:0] ent_busy;
  logic [NUM_ENT-1:0] ent_busy_next;
  logic [IDX_W:0]     busy_count_d;
  logic [IDX_W:0]     busy_count_q;

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
    logic ren_hit;
    // Indices at or above XZR never match an entry, so XZR and
    // out-of-range renames fall away here.
    assign ren_hit = ren_valid && (ren_idx == IDX_W'(i));

    reg_status_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .ren_hit   (ren_hit),
      .ren_tag   (ren_tag),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .flush     (flush),
      .value_q   (ent_value[i]),
      .busy_q    (ent_busy[i]),
      .tag_q     (ent_tag[i]),
      .busy_next (ent_busy_next[i])
    );
  end

  // Read ports: XZR reads zero; a busy register whose tag is on the CDB
  // this cycle forwards the broadcast value as ready.
  always_comb begin
    logic [IDX_W-1:0] idx;
    rd_value = '0;
    rd_busy  = '0;
    rd_tag   = '0;
    idx      = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx = rd_idx[p*IDX_W +: IDX_W];
      if (idx < IDX_W'(NUM_ENT)) begin
        rd_tag[p*TAG_W +: TAG_W] = ent_tag[idx];
        if (ent_busy[idx] && cdb_valid && (ent_tag[idx] == cdb_tag)) begin
          rd_value[p*DATA_W +: DATA_W] = cdb_value;
        end else begin
          rd_value[p*DATA_W +: DATA_W] = ent_value[idx];
          rd_busy[p]                   = ent_busy[idx];
        end
      end
    end
  end

  // Popcount of the next-state busy vector.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      busy_count_d = busy_count_d + {{IDX_W{1'b0}}, ent_busy_next[i]};
    end
  end

  // Registered busy count, aligned with the entries' own state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_count_q <= '0;
    else     busy_count_q <= busy_count_d;
  end

  assign busy_count = busy_count_q;

endmodule : reg_status_file

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: stimulus pushes expected read and
// count results into a queue, a negedge monitor pops and compares them.
module tb_reg_status_file;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int TAG_W    = 4;
  localparam int NUM_RD   = 2;
  localparam int IDX_W    = 5;
  localparam int XZR      = NUM_REGS - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*IDX_W-1:0]  rd_idx;
  logic [NUM_RD*DATA_W-1:0] rd_value;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic                     ren_valid;
  logic [IDX_W-1:0]         ren_idx;
  logic [TAG_W-1:0]         ren_tag;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic                     flush;
  logic [IDX_W:0]           busy_count;

  reg_status_file #(
    .NUM_REGS (NUM_REGS), .DATA_W (DATA_W), .TAG_W (TAG_W), .NUM_RD (NUM_RD)
  ) dut (
    .clk (clk), .rst (rst), .rd_idx (rd_idx), .rd_value (rd_value),
    .rd_busy (rd_busy), .rd_tag (rd_tag), .ren_valid (ren_valid),
    .ren_idx (ren_idx), .ren_tag (ren_tag), .cdb_valid (cdb_valid),
    .cdb_tag (cdb_tag), .cdb_value (cdb_value), .flush (flush),
    .busy_count (busy_count)
  );

  always #5 clk = ~clk;

  // Architectural reference state.
  logic [DATA_W-1:0] m_val  [NUM_REGS];
  bit                m_busy [NUM_REGS];
  int                m_tag  [NUM_REGS];

  typedef struct {
    string             name;
    int                port;    // -1 = busy_count check
    logic [DATA_W-1:0] value;
    bit                busy;
    int                tag;
    int                count;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: reads are combinational, so everything queued for this cycle
  // is compared half a clock after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.port < 0) begin
          check({e.name, ".count"}, 64'(busy_count), 64'(e.count));
        end else begin
          check({e.name, ".busy"}, 64'(rd_busy[e.port]), 64'(e.busy));
          if (e.busy) check({e.name, ".tag"}, 64'(rd_tag[e.port*TAG_W +: TAG_W]), 64'(e.tag));
          else        check({e.name, ".value"}, rd_value[e.port*DATA_W +: DATA_W], e.value);
        end
      end
    end
  end

  function automatic int model_count();
    int c = 0;
    for (int r = 0; r < NUM_REGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_val[r] = '0; m_busy[r] = 0; m_tag[r] = 0;
    end
  endtask

  // Expected result of reading register r with the current CDB inputs.
  task automatic push_read(input string name, input int port, input int r);
    exp_t e;
    e.name = name; e.port = port; e.count = 0;
    e.value = '0; e.busy = 0; e.tag = 0;
    if (r != XZR) begin
      if (m_busy[r] && cdb_valid && m_tag[r] == int'(cdb_tag)) begin
        e.value = cdb_value;
      end else if (!m_busy[r]) begin
        e.value = m_val[r];
      end else begin
        e.busy = 1; e.tag = m_tag[r];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic push_count(input string name);
    exp_t e;
    e.name = name; e.port = -1; e.value = '0; e.busy = 0; e.tag = 0;
    e.count = model_count();
    exp_q.push_back(e);
  endtask

  // One cycle: apply inputs, queue expectations, take the edge, advance model.
  task automatic cycle(input string name,
                       input bit rv, input int ri, input int rt,
                       input bit cv, input int ct, input logic [DATA_W-1:0] cval,
                       input bit fl, input int r0, input int r1);
    ren_valid = rv; ren_idx = IDX_W'(ri); ren_tag = TAG_W'(rt);
    cdb_valid = cv; cdb_tag = TAG_W'(ct); cdb_value = cval;
    flush = fl;
    rd_idx = {IDX_W'(r1), IDX_W'(r0)};
    push_read({name, ".p0"}, 0, r0);
    push_read({name, ".p1"}, 1, r1);
    push_count(name);
    @(posedge clk);
    if (fl) begin
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 0;
    end else begin
      for (int r = 0; r < XZR; r++) begin
        if (cv && m_busy[r] && m_tag[r] == ct) begin
          m_val[r] = cval; m_busy[r] = 0;
        end
      end
      if (rv && ri < XZR) begin
        m_busy[ri] = 1; m_tag[ri] = rt;
      end
    end
    #1;
  endtask

  task automatic idle(input string name, input int r0, input int r1);
    cycle(name, 0, 0, 0, 0, 0, '0, 0, r0, r1);
  endtask

  initial begin
    int ct;
    int pick;
    model_reset();
    rst = 1'b1;
    ren_valid = 0; ren_idx = '0; ren_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_value = '0; flush = 0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle("reset_state", 0, 30);

    // Mid-run reset drops a pending rename.
    cycle("pre_rst_ren", 1, 3, 5, 0, 0, '0, 0, 3, 3);
    idle("pre_rst_busy", 3, 0);
    rst = 1'b1;
    model_reset();
    push_read("in_rst.r3", 0, 3);
    push_count("in_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    idle("post_rst", 3, 3);
    idle("post_rst2", 3, 3);

    // Rename then broadcast with bypass.
    cycle("ren_r3", 1, 3, 5, 0, 0, '0, 0, 3, 2);
    idle("r3_busy", 3, 2);
    cycle("bypass_r3", 0, 0, 0, 1, 5, 64'hDEAD, 0, 3, 3);
    idle("r3_done", 3, 2);

    // WAW: older producer's broadcast must not retire r4.
    cycle("waw_ren1", 1, 4, 1, 0, 0, '0, 0, 4, 4);
    cycle("waw_ren2", 1, 4, 2, 0, 0, '0, 0, 4, 4);
    cycle("waw_cdb1", 0, 0, 0, 1, 1, 64'h55, 0, 4, 4);
    cycle("waw_cdb2", 0, 0, 0, 1, 2, 64'h7, 0, 4, 4);
    idle("waw_done", 4, 4);

    // Rename and CDB on the same register in one cycle.
    cycle("r6_ren3", 1, 6, 3, 0, 0, '0, 0, 6, 6);
    cycle("r6_both", 1, 6, 9, 1, 3, 64'h11, 0, 6, 6);
    idle("r6_after", 6, 6);
    cycle("r6_cdb9", 0, 0, 0, 1, 9, 64'h22, 0, 6, 6);
    idle("r6_done", 6, 6);

    // Flush beats rename and CDB.
    cycle("fl_ren10", 1, 10, 7, 0, 0, '0, 0, 10, 11);
    cycle("fl_ren11", 1, 11, 8, 0, 0, '0, 0, 10, 11);
    cycle("fl_ren12", 1, 12, 10, 0, 0, '0, 0, 10, 12);
    cycle("flush", 1, 1, 3, 1, 7, 64'hBAD, 1, 10, 1);
    idle("fl_after", 10, 1);
    idle("fl_after2", 11, 12);

    // XZR rename ignored; two ports bypass the same tag.
    cycle("xzr_ren", 1, XZR, 2, 0, 0, '0, 0, XZR, XZR);
    idle("xzr_read", XZR, XZR);
    cycle("tag4_a", 1, 8, 4, 0, 0, '0, 0, 8, 9);
    cycle("tag4_b", 1, 9, 4, 0, 0, '0, 0, 8, 9);
    cycle("tag4_cdb", 0, 0, 0, 1, 4, 64'hCAFE_F00D_1234_5678, 0, 8, 9);
    idle("tag4_done", 8, 9);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      ct = int'($urandom_range(0, 15));
      pick = int'($urandom_range(0, XZR - 1));
      if (m_busy[pick] && $urandom_range(0, 3) != 0) ct = m_tag[pick];
      cycle($sformatf("rnd%0d", n),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, NUM_REGS - 1)),
            int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), ct, {$urandom, $urandom},
            ($urandom_range(0, 31) == 0),
            int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_status_file
